reg_select_sb: RTL

- Parametrised register select/encode unit with a per-register pending-write scoreboard, for the general-purpose register file datapath.
- Decodes the ra/rb/rc field chosen by Gra/Grb/Grc from IR into one-hot Rin/Rout strobes.
- Holds the last selected index in a register, applies the R0 base-address-zero rule, and stalls register reads whose target has an outstanding write.
- Sits between the control unit and the register file enables.

---
 rtl/reg_sel_pkg.sv | 25 ++
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/reg_select_sb.sv | 116 +++++++++++
 3 files changed

// File: rtl/reg_sel_pkg.sv
// reg_sel_pkg: shared constants and helpers for the register select /
// scoreboard unit.
//   MAX_REGS / MAX_IDX_W : largest supported register file (32 entries)
//   *_DEF                : default register count and IR field positions
//   onehot()             : index -> one-hot mask, sized for MAX_REGS; callers
//                          keep the low NUM_REGS bits
package reg_sel_pkg;

    localparam int MAX_REGS     = 32;
    localparam int MAX_IDX_W    = 5;
    localparam int NUM_REGS_DEF = 16;
    localparam int RA_LSB_DEF   = 23;
    localparam int RB_LSB_DEF   = 19;
    localparam int RC_LSB_DEF   = 15;

    typedef logic [MAX_REGS-1:0] reg_mask_t;

    function automatic reg_mask_t onehot(input logic [MAX_IDX_W-1:0] idx);
        reg_mask_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one pending-write bit per register plus a sticky WAW flag.
//   clk, clr           : clock, async active-high reset
//   issue_wr, set_idx  : mark set_idx as having an outstanding write
//   retire_wr, retire_idx : clear the pending bit of retire_idx
//   rd_idx, rd_hit     : read lookup; a same-cycle retire of rd_idx masks the hit
//   pending_vec        : scoreboard contents
//   err_waw            : sticky, issue to a register still pending
module reg_scoreboard
    import reg_sel_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                issue_wr,
    input  logic [IDX_W-1:0]    set_idx,
    input  logic                retire_wr,
    input  logic [IDX_W-1:0]    retire_idx,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic                rd_hit,
    output logic [NUM_REGS-1:0] pending_vec,
    output logic                err_waw
);

    logic                set_retiring;
    logic                rd_retiring;
    logic [NUM_REGS-1:0] pend_nxt;

    assign set_retiring = retire_wr && (retire_idx == set_idx);
    assign rd_retiring  = retire_wr && (retire_idx == rd_idx);
    assign rd_hit       = pending_vec[rd_idx] && !rd_retiring;

    // Clear first, then set, so a same-index set/clear leaves the bit set.
    always_comb begin
        pend_nxt = pending_vec;
        if (retire_wr) pend_nxt[retire_idx] = 1'b0;
        if (issue_wr)  pend_nxt[set_idx]    = 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pending_vec <= '0;
            err_waw     <= 1'b0;
        end else begin
            pending_vec <= pend_nxt;
            if (issue_wr && pending_vec[set_idx] && !set_retiring)
                err_waw <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_select_sb.sv
// reg_select_sb: picks ra/rb/rc from IR (Gra > Grb > Grc, else the held
// index), turns it into one-hot register load/drive strobes, handles the
// R0-as-zero base-address case and stalls reads of registers with an
// outstanding write.
//   clk, clr              : clock, async active-high reset
//   Gra/Grb/Grc, IR       : field select and instruction register
//   Rin/Rout/BAout        : strobe requests (Rin has priority)
//   issue_wr, retire_wr, retire_idx : scoreboard updates (ra field is the set index)
//   Rin_vec/Rout_vec      : one-hot load / bus-drive enables
//   zero_out              : drive constant 0 for BAout of R0
//   sel_idx, stall        : effective index, read blocked by pending write
//   pending_vec, err_waw  : scoreboard contents, sticky WAW error
module reg_select_sb
    import reg_sel_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int IDX_W      = $clog2(NUM_REGS),
    parameter int IR_W       = 32,
    parameter int RA_LSB     = RA_LSB_DEF,
    parameter int RB_LSB     = RB_LSB_DEF,
    parameter int RC_LSB     = RC_LSB_DEF,
    parameter bit BA_ZERO_R0 = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                Gra,
    input  logic                Grb,
    input  logic                Grc,
    input  logic                Rin,
    input  logic                Rout,
    input  logic                BAout,
    input  logic [IR_W-1:0]     IR,
    input  logic                issue_wr,
    input  logic                retire_wr,
    input  logic [IDX_W-1:0]    retire_idx,
    output logic [NUM_REGS-1:0] Rin_vec,
    output logic [NUM_REGS-1:0] Rout_vec,
    output logic                zero_out,
    output logic [IDX_W-1:0]    sel_idx,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending_vec,
    output logic                err_waw
);

    if (RA_LSB + IDX_W > IR_W || RB_LSB + IDX_W > IR_W || RC_LSB + IDX_W > IR_W)
    begin : g_bad_fields
        $error("reg_select_sb: IR field does not fit in IR_W");
    end
    if (NUM_REGS < 2 || NUM_REGS > MAX_REGS || (1 << IDX_W) != NUM_REGS)
    begin : g_bad_regs
        $error("reg_select_sb: NUM_REGS must be a power of two in 2..32");
    end

    logic [IDX_W-1:0] ra, rb, rc;
    logic [IDX_W-1:0] held_idx;
    logic [IDX_W-1:0] cur_idx;
    reg_mask_t        sel_oh;
    logic             rd_hit;
    logic             unused_bits;

    assign ra = IR[RA_LSB +: IDX_W];
    assign rb = IR[RB_LSB +: IDX_W];
    assign rc = IR[RC_LSB +: IDX_W];

    always_comb begin
        cur_idx = held_idx;
        if (Gra)      cur_idx = ra;
        else if (Grb) cur_idx = rb;
        else if (Grc) cur_idx = rc;
    end

    assign sel_idx = cur_idx;
    assign sel_oh  = onehot(MAX_IDX_W'(cur_idx));

    // With no G* asserted cur_idx is held_idx, so this holds its value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) held_idx <= '0;
        else     held_idx <= cur_idx;
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_sb (
        .clk         (clk),
        .clr         (clr),
        .issue_wr    (issue_wr),
        .set_idx     (ra),
        .retire_wr   (retire_wr),
        .retire_idx  (retire_idx),
        .rd_idx      (cur_idx),
        .rd_hit      (rd_hit),
        .pending_vec (pending_vec),
        .err_waw     (err_waw)
    );

    always_comb begin
        Rin_vec  = '0;
        Rout_vec = '0;
        zero_out = 1'b0;
        stall    = 1'b0;
        if (Rin) begin
            Rin_vec = sel_oh[NUM_REGS-1:0];
        end else if (BAout && BA_ZERO_R0 && cur_idx == '0) begin
            // Base address through R0 means literal zero; never stalled.
            zero_out = 1'b1;
        end else if (Rout || BAout) begin
            stall = rd_hit;
            if (!rd_hit) Rout_vec = sel_oh[NUM_REGS-1:0];
        end
    end

    // Only the field bits of IR and the low NUM_REGS one-hot bits matter.
    assign unused_bits = ^{IR, sel_oh};

endmodule
